// File: rtl/register_file.sv
// 16-entry architectural register file: two combinational read ports, one
// synchronous write port, with the top address aliased to the external PC value.
`timescale 1ns/1ps
module register_file #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  WE3,
  input  logic [ADDR_WIDTH-1:0] A1,
  input  logic [ADDR_WIDTH-1:0] A2,
  input  logic [ADDR_WIDTH-1:0] A3,
  input  logic [DATA_WIDTH-1:0] WD3,
  input  logic [DATA_WIDTH-1:0] R15,
  output logic [DATA_WIDTH-1:0] RD1,
  output logic [DATA_WIDTH-1:0] RD2
);

  localparam int                  NUM_REGS = (1 << ADDR_WIDTH) - 1;
  localparam logic [ADDR_WIDTH-1:0] PC_ADDR  = '1;

  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];
  logic                  write_en;

  // The PC address has no backing storage, so writes to it are dropped here.
  assign write_en = WE3 && (A3 != PC_ADDR);

  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      regs_d[i] = regs_q[i];
    end
    if (write_en) begin
      regs_d[A3] = WD3;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  // Reads come straight from storage with no write bypass: a same-cycle
  // write becomes visible only after the clock edge.
  always_comb begin
    RD1 = (A1 == PC_ADDR) ? R15 : regs_q[A1];
    RD2 = (A2 == PC_ADDR) ? R15 : regs_q[A2];
  end

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: directed scenarios plus randomized
// traffic checked against an array-based reference model.
`timescale 1ns/1ps
module tb_register_file;

  localparam int DW = 32;
  localparam int AW = 4;
  localparam int NR = 15;

  logic          clk = 1'b0;
  logic          rst;
  logic          WE3;
  logic [AW-1:0] A1, A2, A3;
  logic [DW-1:0] WD3, R15, RD1, RD2;

  int vectors     = 0;
  int miscompares = 0;

  logic [DW-1:0] model [NR];

  register_file #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .WE3(WE3), .A1(A1), .A2(A2), .A3(A3),
    .WD3(WD3), .R15(R15), .RD1(RD1), .RD2(RD2)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout, wanted finish");
    $fatal(1);
  end

  // Reference model: plain array, top address reads the PC input
  function automatic logic [DW-1:0] ref_read(input logic [AW-1:0] a);
    if (a == AW'(NR)) return R15;
    return model[a];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NR; i++) model[i] = '0;
  endtask

  // Driver: one write transaction, model updated at the same edge
  task automatic drive_write(input logic [AW-1:0] addr, input logic [DW-1:0] data);
    @(negedge clk);
    WE3 = 1'b1; A3 = addr; WD3 = data;
    @(posedge clk);
    if (addr != AW'(NR)) model[addr] = data;
    #1;
    WE3 = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; WE3 = 1'b0; A1 = '0; A2 = '0; A3 = '0; WD3 = '0; R15 = 32'h0000_55AA;
    model_reset();
    #50;
    for (int i = 0; i < NR; i++) begin
      A1 = AW'(i); A2 = AW'(NR - 1 - i);
      #1;
      vectors++;
      if (RD1 !== 32'h0) begin
        miscompares++;
        $display("FAIL reset_rd1 a=%0d got %h wanted %h", i, RD1, 32'h0);
      end
      vectors++;
      if (RD2 !== 32'h0) begin
        miscompares++;
        $display("FAIL reset_rd2 a=%0d got %h wanted %h", NR - 1 - i, RD2, 32'h0);
      end
    end
    A1 = 4'hF; #1;
    vectors++;
    if (RD1 !== 32'h0000_55AA) begin
      miscompares++;
      $display("FAIL reset_pc got %h wanted %h", RD1, 32'h0000_55AA);
    end
    // A write attempted while reset is held must not land
    @(negedge clk);
    WE3 = 1'b1; A3 = 4'd5; WD3 = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    WE3 = 1'b0; A1 = 4'd5; #1;
    vectors++;
    if (RD1 !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_write_ignored got %h wanted %h", RD1, 32'h0);
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_write_read();
    drive_write(4'd0, 32'h0000_01DA);
    drive_write(4'd1, 32'h0000_FFFF);
    @(negedge clk);
    A1 = 4'd0; A2 = 4'd1; #1;
    vectors++;
    if (RD1 !== 32'h0000_01DA) begin
      miscompares++;
      $display("FAIL wr_rd1 got %h wanted %h", RD1, 32'h0000_01DA);
    end
    vectors++;
    if (RD2 !== 32'h0000_FFFF) begin
      miscompares++;
      $display("FAIL wr_rd2 got %h wanted %h", RD2, 32'h0000_FFFF);
    end
  endtask

  task automatic test_we_gating();
    @(negedge clk);
    WE3 = 1'b0; A3 = 4'd0; WD3 = 32'h0; A1 = 4'd0;
    repeat (4) @(posedge clk);
    #1;
    vectors++;
    if (RD1 !== 32'h0000_01DA) begin
      miscompares++;
      $display("FAIL we_gating got %h wanted %h", RD1, 32'h0000_01DA);
    end
  endtask

  task automatic test_reg10();
    drive_write(4'hA, 32'h0A00_D3F1);
    @(negedge clk);
    A1 = 4'd1; A2 = 4'hA; #1;
    vectors++;
    if (RD1 !== 32'h0000_FFFF) begin
      miscompares++;
      $display("FAIL reg10_rd1 got %h wanted %h", RD1, 32'h0000_FFFF);
    end
    vectors++;
    if (RD2 !== 32'h0A00_D3F1) begin
      miscompares++;
      $display("FAIL reg10_rd2 got %h wanted %h", RD2, 32'h0A00_D3F1);
    end
  endtask

  task automatic test_pc_alias();
    @(negedge clk);
    R15 = 32'h0000_0108; A1 = 4'hF; #1;
    vectors++;
    if (RD1 !== 32'h0000_0108) begin
      miscompares++;
      $display("FAIL pc_read got %h wanted %h", RD1, 32'h0000_0108);
    end
    drive_write(4'hF, 32'hDEAD_BEEF);
    #1;
    vectors++;
    if (RD1 !== 32'h0000_0108) begin
      miscompares++;
      $display("FAIL pc_write_dropped got %h wanted %h", RD1, 32'h0000_0108);
    end
    // R15 changes must appear on both ports without a clock
    A2 = 4'hF; R15 = 32'h0000_0200; #1;
    vectors++;
    if (RD1 !== 32'h0000_0200 || RD2 !== 32'h0000_0200) begin
      miscompares++;
      $display("FAIL pc_propagate got %h/%h wanted %h", RD1, RD2, 32'h0000_0200);
    end
    for (int i = 0; i < NR; i++) begin
      A2 = AW'(i); #1;
      vectors++;
      if (RD2 !== model[i]) begin
        miscompares++;
        $display("FAIL pc_regs_unchanged a=%0d got %h wanted %h", i, RD2, model[i]);
      end
    end
  endtask

  task automatic test_read_during_write();
    drive_write(4'd2, 32'hCAFE_0002);
    @(negedge clk);
    A1 = 4'd2; A2 = 4'd2; A3 = 4'd2; WE3 = 1'b1; WD3 = 32'h1234_5678; #1;
    vectors++;
    if (RD1 !== 32'hCAFE_0002 || RD2 !== 32'hCAFE_0002) begin
      miscompares++;
      $display("FAIL rdw_before got %h/%h wanted %h", RD1, RD2, 32'hCAFE_0002);
    end
    @(posedge clk);
    model[2] = 32'h1234_5678;
    #1;
    WE3 = 1'b0;
    vectors++;
    if (RD1 !== 32'h1234_5678 || RD2 !== 32'h1234_5678) begin
      miscompares++;
      $display("FAIL rdw_after got %h/%h wanted %h", RD1, RD2, 32'h1234_5678);
    end
  endtask

  task automatic test_async_reset();
    drive_write(4'd3, 32'h3333_3333);
    drive_write(4'd14, 32'hEEEE_000E);
    @(negedge clk);
    WE3 = 1'b1; A3 = 4'd3; WD3 = 32'h0000_0BAD; A1 = 4'd3; A2 = 4'd14;
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    vectors++;
    if (RD1 !== 32'h0 || RD2 !== 32'h0) begin
      miscompares++;
      $display("FAIL async_reset_immediate got %h/%h wanted %h", RD1, RD2, 32'h0);
    end
    @(posedge clk); #1;
    WE3 = 1'b0;
    for (int i = 0; i < NR; i++) begin
      A1 = AW'(i); #1;
      vectors++;
      if (RD1 !== 32'h0) begin
        miscompares++;
        $display("FAIL async_reset_sweep a=%0d got %h wanted %h", i, RD1, 32'h0);
      end
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    A1 = 4'd3; #1;
    vectors++;
    if (RD1 !== 32'h0) begin
      miscompares++;
      $display("FAIL pending_write_discarded got %h wanted %h", RD1, 32'h0);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      WE3 = 1'($urandom_range(0, 1));
      A3  = AW'($urandom_range(0, 15));
      WD3 = $urandom;
      A1  = AW'($urandom_range(0, 15));
      A2  = AW'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) R15 = $urandom;
      #1;
      vectors++;
      if (RD1 !== ref_read(A1) || RD2 !== ref_read(A2)) begin
        miscompares++;
        $display("FAIL rand_pre n=%0d got %h/%h wanted %h/%h", n, RD1, RD2, ref_read(A1), ref_read(A2));
      end
      @(posedge clk);
      if (WE3 && A3 != AW'(NR)) model[A3] = WD3;
      #1;
      vectors++;
      if (RD1 !== ref_read(A1) || RD2 !== ref_read(A2)) begin
        miscompares++;
        $display("FAIL rand_post n=%0d got %h/%h wanted %h/%h", n, RD1, RD2, ref_read(A1), ref_read(A2));
      end
    end
    WE3 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_we_gating();
    test_reg10();
    test_pc_alias();
    test_read_during_write();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
